// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions: MEM stage FSM states and byte-lane constants.
package arm_pipe_pkg;

    // MEM stage access FSM: IDLE accepts a new op, WAIT holds it until mem_ack
    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // Byte-lane write enables, lane 0 = bits [7:0]
    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_B0   = 4'b0001;
    localparam logic [3:0] LANE_ALL  = 4'b1111;

    // One-hot lane enable for a byte at the given word offset
    function automatic logic [3:0] byte_lane(input logic [1:0] offset);
        return LANE_B0 << offset;
    endfunction

endpackage

// File: rtl/arm_load_align.sv
// Combinational lane handling for the MEM stage: byte select with zero-extend
// on loads, byte replication plus lane enables on stores.
module arm_load_align
    import arm_pipe_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic        byte_access,
    output logic [31:0] load_data,
    output logic [31:0] store_wdata,
    output logic [3:0]  store_lanes
);

    logic [7:0] sel_byte;

    // Pick the addressed byte of the read word and build store lanes
    always_comb begin
        sel_byte = rdata[7:0];
        case (offset)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        load_data   = byte_access ? {24'h000000, sel_byte} : rdata;
        store_wdata = byte_access ? {4{store_data[7:0]}} : store_data;
        store_lanes = byte_access ? byte_lane(offset) : LANE_ALL;
    end

endmodule

// File: rtl/arm_mem_stage.sv
// ARM pipeline MEM stage: issues load/store requests to a handshaked memory,
// stalls the front of the pipe until mem_ack, and registers MEM/WB results.
// Optional feature macro: ARM_MEM_ALIGN_CHECK_EN (word alignment fault check,
// adds the mem_align_fault output).
//
// Memory handshake: mem_req is high whenever a memory op is held in EX/MEM;
// address, data and lane enables are held stable while mem_req is high and
// the op completes on the clock edge where mem_req and mem_ack are both high.
module arm_mem_stage
    import arm_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EXMEM_data_result,
    input  logic [31:0] EXMEM_rd_data,
    input  logic        EXMEM_rd_we,
    input  logic        EXMEM_rd_data_sel,
    input  logic [3:0]  EXMEM_des_reg_num,
    input  logic [3:0]  EXMEM_mem_write_en,
    input  logic        EXMEM_ld_byte_or_word,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_stall,
    output logic        MEMWB_rd_we,
    output logic [31:0] MEMWB_rd_data,
    output logic [3:0]  MEMWB_des_reg_num,
`ifdef ARM_MEM_ALIGN_CHECK_EN
    output logic        mem_align_fault,
`endif
    output mem_state_t  dbg_state
);

    mem_state_t  state, state_next;
    logic        is_load, is_store, misaligned, mem_op, complete;
    logic [31:0] load_data, store_wdata;
    logic [3:0]  store_lanes;

    assign is_load  = EXMEM_rd_data_sel;
    assign is_store = |EXMEM_mem_write_en;

`ifdef ARM_MEM_ALIGN_CHECK_EN
    // A misaligned word access never reaches memory; it retires as a bubble
    assign misaligned = (is_load | is_store) & ~EXMEM_ld_byte_or_word &
                        (EXMEM_data_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign mem_op   = (is_load | is_store) & ~misaligned;
    assign complete = ~mem_op | mem_ack;

    arm_load_align u_align (
        .rdata       (mem_rdata),
        .offset      (EXMEM_data_result[1:0]),
        .store_data  (EXMEM_rd_data),
        .byte_access (EXMEM_ld_byte_or_word),
        .load_data   (load_data),
        .store_wdata (store_wdata),
        .store_lanes (store_lanes)
    );

    // Request side is purely combinational off the held EX/MEM contents
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = LANE_NONE;
        mem_stall = 1'b0;
        mem_addr  = EXMEM_ld_byte_or_word ? EXMEM_data_result
                                          : {EXMEM_data_result[31:2], 2'b00};
        mem_wdata = store_wdata;
        if (!rst) begin
            mem_req   = mem_op;
            mem_stall = mem_op & ~mem_ack;
            if (mem_op && is_store) begin
                mem_we = store_lanes;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: wait out un-acked accesses
    always_comb begin
        state_next = state;
        case (state)
            MEM_IDLE: if (mem_op && !mem_ack) state_next = MEM_WAIT;
            MEM_WAIT: if (mem_ack || !mem_op) state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    assign dbg_state = state;

    // MEM/WB register: load on completion, bubble while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            MEMWB_rd_we       <= 1'b0;
            MEMWB_rd_data     <= 32'h0;
            MEMWB_des_reg_num <= 4'h0;
        end else if (complete) begin
            MEMWB_rd_we       <= EXMEM_rd_we & ~misaligned;
            MEMWB_rd_data     <= (is_load && mem_op) ? load_data : EXMEM_data_result;
            MEMWB_des_reg_num <= EXMEM_des_reg_num;
        end else begin
            MEMWB_rd_we       <= 1'b0;
        end
    end

`ifdef ARM_MEM_ALIGN_CHECK_EN
    // Alignment fault flag stays set until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_align_fault <= 1'b0;
        end else if (misaligned) begin
            mem_align_fault <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/arm_mem_stage.md
ARM_MEM_STAGE -- requirements
Module: arm_mem_stage

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock, all state on posedge); rst in 1 (synchronous, active-high reset).
REQ-002 SHALL have EX/MEM inputs: EXMEM_data_result in 32 (ALU result or address); EXMEM_rd_data in 32 (store data); EXMEM_rd_we in 1; EXMEM_rd_data_sel in 1 (1=load, 0=ALU result); EXMEM_des_reg_num in 4; EXMEM_mem_write_en in 4 (nonzero=store); EXMEM_ld_byte_or_word in 1 (1=byte, 0=word).
REQ-003 SHALL have memory ports: mem_req out 1; mem_addr out 32; mem_wdata out 32; mem_we out 4 (byte-lane enables); mem_rdata in 32; mem_ack in 1.
REQ-004 SHALL have outputs: mem_stall out 1 (freeze IF/ID/EX and hold EXMEM_*); MEMWB_rd_we out 1; MEMWB_rd_data out 32; MEMWB_des_reg_num out 4; mem_align_fault out 1 (only with ARM_MEM_ALIGN_CHECK_EN).

Function
REQ-005 SHALL classify a memory op as EXMEM_rd_data_sel=1 (load) or EXMEM_mem_write_en!=0 (store); all other ops are pass-through.
REQ-006 SHALL implement FSM IDLE/WAIT: IDLE with memory op and mem_ack=0 -> WAIT; WAIT with mem_ack=1 -> IDLE; otherwise stay.
REQ-007 SHALL assert mem_req combinationally whenever a memory op is present in IDLE or WAIT, and hold mem_addr/mem_wdata/mem_we stable until the mem_ack cycle.
REQ-008 SHALL drive mem_addr = {EXMEM_data_result[31:2],2'b00} for word, EXMEM_data_result for byte.
REQ-009 SHALL, for byte store, drive mem_wdata = rd_data[7:0] replicated to all four lanes and mem_we = 4'b0001 << addr[1:0]; word store drives mem_wdata = rd_data, mem_we = 4'b1111; loads drive mem_we = 0.
REQ-010 SHALL assert mem_stall = memory op & ~mem_ack (combinational); zero-wait memory (ack in request cycle) causes no stall.
REQ-011 SHALL complete an op in the cycle mem_ack=1 (or immediately for pass-through) and register MEMWB_* on that clock edge: 1-cycle latency beyond memory wait.
REQ-012 SHALL set MEMWB_rd_data = word load: mem_rdata; byte load: zero-extended mem_rdata byte selected by addr[1:0]; else EXMEM_data_result.
REQ-013 SHALL set MEMWB_rd_we = EXMEM_rd_we and MEMWB_des_reg_num = EXMEM_des_reg_num on completion; on every stalled cycle MEMWB_rd_we SHALL be 0 (bubble), other MEMWB fields may hold.
REQ-014 SHALL ignore mem_ack when no memory op is present and in IDLE.
REQ-015 SHALL never issue a second request for the same op: after ack, next cycle's EXMEM content is treated as a new op.

Reset
REQ-016 SHALL on rst: state=IDLE, MEMWB_rd_we=0, MEMWB_rd_data=0, MEMWB_des_reg_num=0, mem_align_fault=0.
REQ-017 SHALL, while rst=1, force mem_req=0, mem_we=0, mem_stall=0 regardless of inputs; reset during WAIT abandons the access.

Configuration
REQ-018 SHALL, with ARM_MEM_ALIGN_CHECK_EN defined, detect word access with addr[1:0]!=0: mem_req suppressed, op completes in one cycle with MEMWB_rd_we=0, mem_align_fault set sticky until rst.
REQ-019 SHALL, without ARM_MEM_ALIGN_CHECK_EN, omit mem_align_fault port and ignore addr[1:0] for word access.

Structure
REQ-020 SHALL place the FSM state enum (MEM_IDLE, MEM_WAIT) and byte-lane constants in shared package arm_pipe_pkg.
REQ-021 SHALL use one sub-module arm_load_align (combinational byte select/zero-extend and store lane replication).

Verification
REQ-022 Pass-through: rd_data_sel=0, data_result=0x1234, rd_we=1, des=5 -> next cycle MEMWB_rd_data=0x1234, we=1, des=5, no mem_req, no stall.
REQ-023 Word load, ack after 3 cycles: addr 0x100, rdata 0xDEADBEEF -> mem_stall=1 for 3 cycles, MEMWB_rd_we=0 those cycles, then MEMWB_rd_data=0xDEADBEEF.
REQ-024 Byte load addr 0x103, rdata 0xAABBCCDD, zero-wait -> MEMWB_rd_data=0x000000AA, no stall.
REQ-025 Byte store addr 0x102, rd_data 0x5A -> mem_we=4'b0100, mem_wdata=0x5A5A5A5A, MEMWB_rd_we=0.
REQ-026 rst asserted in WAIT -> next cycle mem_req=0, mem_stall=0, MEMWB_rd_we=0, state IDLE.
REQ-027 With ARM_MEM_ALIGN_CHECK_EN: word load addr 0x102 -> no mem_req, mem_align_fault=1 held, MEMWB_rd_we=0.
